// File: rtl/sample_feeder_pkg.sv
// Shared definitions for the sample feeder: FSM state encoding, default sample
// width, counter width and a saturating-increment helper.
package sample_feeder_pkg;

   localparam int unsigned DWIDTH_DEFAULT = 16;
   localparam int unsigned CNT_W          = 16;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ACK     = 2'd1,
      RELEASE = 2'd2
   } fsm_state_e;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == '1) ? v : v + 1'b1;
   endfunction

endpackage

// File: rtl/sample_feeder_fifo.sv
// Circular sample FIFO: storage, wrapping pointers, occupancy and registered
// empty/full flags that already reflect the current edge's push and pop.
module sample_fifo #(
   parameter int unsigned DWIDTH    = 16,
   parameter int unsigned DEPTH     = 8,
   parameter int unsigned DEPTH_LOG = 3
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 push,
   input  logic                 pop,
   input  logic [0:DWIDTH-1]    wr_data,
   output logic [0:DWIDTH-1]    rd_data,
   output logic [DEPTH_LOG:0]   level,
   output logic                 empty,
   output logic                 full
);

   logic [0:DWIDTH-1]    mem_q [DEPTH];
   logic [DEPTH_LOG-1:0] wr_ptr_q, wr_ptr_d;
   logic [DEPTH_LOG-1:0] rd_ptr_q, rd_ptr_d;
   logic [DEPTH_LOG:0]   level_q, level_d;
   logic                 empty_q, empty_d;
   logic                 full_q, full_d;
   logic                 do_push, do_pop;

   // A same-edge pop frees the slot, so a push while full still lands.
   always_comb begin
      do_pop   = pop && !empty_q;
      do_push  = push && (!full_q || do_pop);
      wr_ptr_d = wr_ptr_q + DEPTH_LOG'(do_push);
      rd_ptr_d = rd_ptr_q + DEPTH_LOG'(do_pop);
      level_d  = level_q + (DEPTH_LOG+1)'(do_push) - (DEPTH_LOG+1)'(do_pop);
      empty_d  = (level_d == '0);
      full_d   = (level_d == (DEPTH_LOG+1)'(DEPTH));
   end

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem_q[wr_ptr_q] <= wr_data;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
         empty_q  <= 1'b1;
         full_q   <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
         empty_q  <= empty_d;
         full_q   <= full_d;
      end
   end

   assign rd_data = mem_q[rd_ptr_q];
   assign level   = level_q;
   assign empty   = empty_q;
   assign full    = full_q;

endmodule

// File: rtl/sample_feeder.sv
// Sample feeder: buffers strobed samples and serves them over four-phase
// req/ack. Define SAMPLE_FEEDER_UNDERFLOW_FILL_EN to answer an empty FIFO with zero fill.
module sample_feeder
   import sample_feeder_pkg::*;
#(
   parameter int unsigned DWIDTH    = DWIDTH_DEFAULT,
   parameter int unsigned DEPTH     = 8,
   parameter int unsigned DEPTH_LOG = 3
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   input  logic [0:DWIDTH-1]    in_data,
   input  logic                 req,
   output logic                 ack,
   output logic [0:DWIDTH-1]    data_out,
   output logic [DEPTH_LOG:0]   level,
   output logic                 empty,
   output logic                 full,
   output logic [CNT_W-1:0]     overflow_cnt
`ifdef SAMPLE_FEEDER_UNDERFLOW_FILL_EN
   ,
   output logic [CNT_W-1:0]     underflow_cnt
`endif
);

   localparam logic [1:0] ST_IDLE    = IDLE;
   localparam logic [1:0] ST_ACK     = ACK;
   localparam logic [1:0] ST_RELEASE = RELEASE;

   logic [1:0]          state_q, state_d;
   logic                ack_q, ack_d;
   logic [0:DWIDTH-1]   data_q, data_d;
   logic [CNT_W-1:0]    ovf_q, ovf_d;
   logic                fifo_push, fifo_pop;
   logic [0:DWIDTH-1]   fifo_rd;
   logic                fifo_empty, fifo_full;
`ifdef SAMPLE_FEEDER_UNDERFLOW_FILL_EN
   logic [CNT_W-1:0]    unf_q, unf_d;
`endif

   sample_fifo #(
      .DWIDTH    (DWIDTH),
      .DEPTH     (DEPTH),
      .DEPTH_LOG (DEPTH_LOG)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .push    (fifo_push),
      .pop     (fifo_pop),
      .wr_data (in_data),
      .rd_data (fifo_rd),
      .level   (level),
      .empty   (fifo_empty),
      .full    (fifo_full)
   );

   assign fifo_push = in_valid && !rst;

   // The head is captured into data_q on the same edge it is popped.
   always_comb begin
      state_d  = state_q;
      data_d   = data_q;
      ovf_d    = ovf_q;
      fifo_pop = 1'b0;
`ifdef SAMPLE_FEEDER_UNDERFLOW_FILL_EN
      unf_d    = unf_q;
`endif
      case (state_q)
         ST_IDLE: begin
            if (req && !fifo_empty) begin
               state_d  = ST_ACK;
               fifo_pop = 1'b1;
               data_d   = fifo_rd;
            end
`ifdef SAMPLE_FEEDER_UNDERFLOW_FILL_EN
            else if (req) begin
               state_d = ST_ACK;
               data_d  = '0;
               unf_d   = sat_inc(unf_q);
            end
`endif
         end
         ST_ACK: begin
            if (!req) begin
               state_d = ST_RELEASE;
            end
         end
         ST_RELEASE: state_d = ST_IDLE;
         default:    state_d = ST_IDLE;
      endcase
      if (in_valid && fifo_full && !fifo_pop) begin
         ovf_d = sat_inc(ovf_q);
      end
      ack_d = (state_d == ST_ACK);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         ack_q   <= 1'b0;
         data_q  <= '0;
         ovf_q   <= '0;
`ifdef SAMPLE_FEEDER_UNDERFLOW_FILL_EN
         unf_q   <= '0;
`endif
      end else begin
         state_q <= state_d;
         ack_q   <= ack_d;
         data_q  <= data_d;
         ovf_q   <= ovf_d;
`ifdef SAMPLE_FEEDER_UNDERFLOW_FILL_EN
         unf_q   <= unf_d;
`endif
      end
   end

   assign ack          = ack_q;
   assign data_out     = data_q;
   assign empty        = fifo_empty;
   assign full         = fifo_full;
   assign overflow_cnt = ovf_q;
`ifdef SAMPLE_FEEDER_UNDERFLOW_FILL_EN
   assign underflow_cnt = unf_q;
`endif

endmodule

// File: tb/tb_sample_feeder.sv
// Directed bench for sample_feeder: vector table for fill-up, hand sequences
// for handshakes, overflow, simultaneous push/pop, empty request and reset.
module tb_sample_feeder;

   logic         clk = 1'b0;
   logic         rst;
   logic         in_valid;
   logic [0:15]  in_data;
   logic         req;
   logic         ack;
   logic [0:15]  data_out;
   logic [3:0]   level;
   logic         empty;
   logic         full;
   logic [15:0]  overflow_cnt;
`ifdef SAMPLE_FEEDER_UNDERFLOW_FILL_EN
   logic [15:0]  underflow_cnt;
`endif

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic        in_valid;
      logic [15:0] in_data;
      logic        req;
      logic [3:0]  exp_level;
      logic        exp_empty;
      logic        exp_full;
      logic        exp_ack;
   } vec_t;

   vec_t vecs[4];

   always #5 clk = ~clk;

   sample_feeder #(
      .DWIDTH    (16),
      .DEPTH     (8),
      .DEPTH_LOG (3)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .in_valid     (in_valid),
      .in_data      (in_data),
      .req          (req),
      .ack          (ack),
      .data_out     (data_out),
      .level        (level),
      .empty        (empty),
      .full         (full),
      .overflow_cnt (overflow_cnt)
`ifdef SAMPLE_FEEDER_UNDERFLOW_FILL_EN
      ,
      .underflow_cnt(underflow_cnt)
`endif
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // Consumer: raise req, wait for ack, optionally hold, then drop req.
   task automatic handshake(input string name, input int hold, input logic [15:0] exp);
      int n;
      n = 0;
      req = 1'b1;
      while (ack !== 1'b1 && n < 20) begin
         tick;
         n++;
      end
      chk({name, "_ack"}, 32'(ack), 32'd1);
      chk({name, "_data"}, 32'(data_out), 32'(exp));
      for (int i = 0; i < hold; i++) begin
         tick;
         chk({name, "_stable"}, {15'd0, ack, data_out}, {15'd0, 1'b1, exp});
      end
      req = 1'b0;
      tick;
      chk({name, "_drop"}, 32'(ack), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      vecs[0] = '{1'b1, 16'h0001, 1'b0, 4'd1, 1'b0, 1'b0, 1'b0};
      vecs[1] = '{1'b1, 16'h7FFF, 1'b0, 4'd2, 1'b0, 1'b0, 1'b0};
      vecs[2] = '{1'b1, 16'h8000, 1'b0, 4'd3, 1'b0, 1'b0, 1'b0};
      vecs[3] = '{1'b0, 16'h0000, 1'b0, 4'd3, 1'b0, 1'b0, 1'b0};

      rst = 1'b1; in_valid = 1'b0; in_data = '0; req = 1'b0;
      tick;
      in_valid = 1'b1; in_data = 16'h1234;
      tick;
      rst = 1'b0; in_valid = 1'b0;
      chk("rst_ack", 32'(ack), 32'd0);
      chk("rst_data", 32'(data_out), 32'd0);
      chk("rst_level", 32'(level), 32'd0);
      chk("rst_empty", 32'(empty), 32'd1);
      chk("rst_full", 32'(full), 32'd0);
      chk("rst_ovf", 32'(overflow_cnt), 32'd0);
`ifdef SAMPLE_FEEDER_UNDERFLOW_FILL_EN
      chk("rst_unf", 32'(underflow_cnt), 32'd0);
`endif

      for (int i = 0; i < 4; i++) begin
         in_valid = vecs[i].in_valid;
         in_data  = vecs[i].in_data;
         req      = vecs[i].req;
         tick;
         chk($sformatf("vec%0d_level", i), 32'(level), 32'(vecs[i].exp_level));
         chk($sformatf("vec%0d_empty", i), 32'(empty), 32'(vecs[i].exp_empty));
         chk($sformatf("vec%0d_full", i), 32'(full), 32'(vecs[i].exp_full));
         chk($sformatf("vec%0d_ack", i), 32'(ack), 32'(vecs[i].exp_ack));
      end

      handshake("hs0", 2, 16'h0001);
      handshake("hs1", 0, 16'h7FFF);
      handshake("hs2", 0, 16'h8000);
      chk("hs_level", 32'(level), 32'd0);
      chk("hs_empty", 32'(empty), 32'd1);

      tick;
`ifdef SAMPLE_FEEDER_UNDERFLOW_FILL_EN
      req = 1'b1;
      tick;
      chk("unf_ack", 32'(ack), 32'd1);
      chk("unf_data", 32'(data_out), 32'd0);
      chk("unf_cnt", 32'(underflow_cnt), 32'd1);
      chk("unf_level", 32'(level), 32'd0);
      req = 1'b0;
      tick;
      chk("unf_drop", 32'(ack), 32'd0);
      tick;
      in_valid = 1'b1; in_data = 16'h1234;
      tick;
      in_valid = 1'b0;
      handshake("lat", 0, 16'h1234);
`else
      req = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick;
         chk("empty_req_ack", 32'(ack), 32'd0);
      end
      in_valid = 1'b1; in_data = 16'h1234;
      tick;
      in_valid = 1'b0;
      chk("lat_ack1", 32'(ack), 32'd0);
      tick;
      chk("lat_ack2", 32'(ack), 32'd1);
      chk("lat_data", 32'(data_out), 32'h1234);
      req = 1'b0;
      tick;
      chk("lat_drop", 32'(ack), 32'd0);
`endif
      chk("lat_level", 32'(level), 32'd0);

      for (int i = 0; i < 10; i++) begin
         in_valid = 1'b1;
         in_data  = 16'h0100 + 16'(i);
         tick;
         chk($sformatf("ovf_level%0d", i), 32'(level), (i + 1 > 8) ? 32'd8 : 32'(i + 1));
      end
      in_valid = 1'b0;
      chk("ovf_full", 32'(full), 32'd1);
      chk("ovf_cnt", 32'(overflow_cnt), 32'd2);

      req = 1'b1; in_valid = 1'b1; in_data = 16'hAAAA;
      tick;
      in_valid = 1'b0;
      chk("pp_level", 32'(level), 32'd8);
      chk("pp_full", 32'(full), 32'd1);
      chk("pp_ovf", 32'(overflow_cnt), 32'd2);
      chk("pp_ack", 32'(ack), 32'd1);
      chk("pp_data", 32'(data_out), 32'h0100);
      req = 1'b0;
      tick;
      chk("pp_drop", 32'(ack), 32'd0);
      for (int k = 1; k < 8; k++) begin
         handshake($sformatf("rd%0d", k), 0, 16'h0100 + 16'(k));
      end
      handshake("rd_wrap", 0, 16'hAAAA);
      chk("rd_level", 32'(level), 32'd0);
      chk("rd_empty", 32'(empty), 32'd1);

      in_valid = 1'b1; in_data = 16'h5555;
      tick;
      in_valid = 1'b0; req = 1'b1;
      tick;
      chk("ra_ack", 32'(ack), 32'd1);
      chk("ra_data", 32'(data_out), 32'h5555);
      in_valid = 1'b1; in_data = 16'h9999;
      tick;
      rst = 1'b1; in_valid = 1'b0;
      tick;
      chk("ra_rst_ack", 32'(ack), 32'd0);
      chk("ra_rst_level", 32'(level), 32'd0);
      chk("ra_rst_empty", 32'(empty), 32'd1);
      chk("ra_rst_data", 32'(data_out), 32'd0);
      rst = 1'b0; req = 1'b0;
      in_valid = 1'b1; in_data = 16'h6666;
      tick;
      in_valid = 1'b0;
      handshake("post_rst", 0, 16'h6666);
      chk("post_rst_level", 32'(level), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/sample_feeder.md
SAMPLE_FEEDER -- requirements
Module: sample_feeder

Interface
REQ-001 Parameter DWIDTH, default 16, sample width in bits.
REQ-002 Parameter DEPTH, default 8, FIFO depth in samples; must be a power of two.
REQ-003 Parameter DEPTH_LOG, default 3, log2(DEPTH).
REQ-004 Reset rst, synchronous, active-high; clock clk.
REQ-005 clk  input  1  rising-edge clock for all state.
REQ-006 rst  input  1  synchronous active-high reset.
REQ-007 in_valid  input  1  one-cycle strobe: in_data holds a new sample.
REQ-008 in_data  input  [0:DWIDTH-1]  signed sample; bit 0 is the MSB.
REQ-009 req  input  1  consumer request (four-phase), connects to the resampler's req_in.
REQ-010 ack  output  1  acknowledge, connects to the resampler's ack_in.
REQ-011 data_out  output  [0:DWIDTH-1]  sample presented with ack; bit 0 is the MSB.
REQ-012 level  output  DEPTH_LOG+1  current FIFO occupancy, 0..DEPTH.
REQ-013 overflow_cnt  output  16  count of dropped input samples.
REQ-014 empty, full  output  1 each  FIFO status flags, both registered.

Function
REQ-015 The block SHALL buffer in_valid samples in a DEPTH-entry circular FIFO and serve them to the consumer over four-phase req/ack, oldest first.
REQ-016 The FSM SHALL have three states: IDLE, ACK, RELEASE.
REQ-017 IDLE->ACK: on a cycle with req=1 and FIFO non-empty, the next cycle SHALL show ack=1 and data_out=head sample, and the head SHALL pop on that same edge.
REQ-018 ACK: ack=1 and data_out SHALL stay stable while req=1. When req=0 is sampled, the FSM SHALL move to RELEASE and ack SHALL be 0 on the next cycle.
REQ-019 RELEASE: ack=0 for at least one cycle, then return to IDLE. Each new transfer SHALL require req sampled high while ack=0, so a consumer holding req continuously gets one sample per handshake.
REQ-020 With req=1 and FIFO empty in IDLE, ack SHALL stay 0 until a sample is available, unless REQ-031 applies.
REQ-021 A push on in_valid SHALL write at the write pointer when not full. Pointers SHALL wrap modulo DEPTH.
REQ-022 Simultaneous push and pop SHALL both take effect, including when full (the pop frees the slot) or when level=1. level SHALL be unchanged in that case.
REQ-023 A push while full without a same-cycle pop SHALL be dropped. overflow_cnt SHALL increment, saturating at 16'hFFFF.
REQ-024 A push into an empty FIFO SHALL NOT bypass: it becomes servable the cycle after it is written (minimum in_valid-to-ack latency is 2 cycles with req high).
REQ-025 level, empty and full SHALL reflect the state after the current edge's push and pop.

Reset
REQ-026 On rst, outputs SHALL be: ack=0, data_out=0, level=0, empty=1, full=0, overflow_cnt=0.
REQ-027 On rst, the FSM SHALL go to IDLE and both pointers SHALL go to 0. FIFO contents are don't-care.
REQ-028 rst asserted in ACK SHALL drop ack on the next edge regardless of req. The popped sample is lost.
REQ-029 in_valid during rst SHALL be ignored.

Configuration
REQ-030 Macro SAMPLE_FEEDER_UNDERFLOW_FILL_EN SHALL select the underflow behaviour.
REQ-031 With the macro defined: req=1 in IDLE with FIFO empty SHALL go to ACK with data_out=0, no pop, and increment a 16-bit saturating underflow_cnt output port that exists only in this build.
REQ-032 Without the macro: REQ-020 behaviour, and no underflow_cnt port.

Structure
REQ-033 A shared package SHALL hold the FSM state enum (IDLE, ACK, RELEASE), the default DWIDTH (16), and the counter width (16).
REQ-034 One sub-module, sample_fifo, SHALL contain storage, pointers, level and flags. sample_feeder SHALL contain the FSM and the counters.

Verification
REQ-035 Reset then push 3 samples (0x0001, 0x7FFF, 0x8000) with req low -> level=3, ack=0, empty=0.
REQ-036 Hold req high after REQ-035 with a consumer that drops req one cycle after ack -> three handshakes delivering 0x0001, 0x7FFF, 0x8000 in order; ack low at least one cycle between them; level=0 at the end.
REQ-037 Push 10 samples back-to-back into DEPTH=8 with no reads -> full=1, level=8, overflow_cnt=2; reading out gives the first 8 samples.
REQ-038 With full=1, push while a pop occurs on the same edge -> level stays 8, overflow_cnt unchanged, and the new sample appears in order after wrap-around.
REQ-039 Assert req with the FIFO empty. Without the macro: ack=0 until a push, then ack 2 cycles after the in_valid. With SAMPLE_FEEDER_UNDERFLOW_FILL_EN: ack on the next cycle with data_out=0 and underflow_cnt=1.
REQ-040 Assert rst while ack=1 -> ack=0 and level=0 after the next edge, and the next handshake starts cleanly from IDLE.
